// File: rtl/sccb_cfg_sequencer.sv
// SCCB register-table sequencer: boots the camera, then raises cam_enable.
// Optional ACK readback and sticky ack_err when SCCB_ACK_CHECK_EN is defined.
module sccb_cfg_sequencer #(
    parameter int          CLK_HZ    = 25_000_000,
    parameter int          SCCB_HZ   = 100_000,
    parameter logic [7:0]  DEV_ID    = 8'h42,
    parameter int          DELAY_CYC = 250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_index,
    input  logic [15:0] rom_entry,
`ifdef SCCB_ACK_CHECK_EN
    input  logic        siod_in,
`endif
    output logic        sioc,
    output logic        siod_out,
    output logic        siod_oe,
    output logic        busy,
    output logic        done,
    output logic        cam_enable,
    output logic        ack_err
);

    localparam int QTR_RAW = CLK_HZ / (4 * SCCB_HZ);
    localparam int QTR     = (QTR_RAW < 1) ? 1 : QTR_RAW;
    localparam int QW      = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int DW      = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, START, BITS, STOP, GAP, DELAY, DONE
    } state_t;

    state_t        state, next_state;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [3:0]    pos;
    logic [1:0]    byte_n;
    logic [26:0]   shreg;
    logic [DW-1:0] dcnt;
    logic          lwait;
    logic          tick, q_end, last_bit, dly_end, bus, ack_hit;

    assign tick     = (qcnt == QW'(QTR - 1));
    assign q_end    = tick && (q == 2'd3);
    assign last_bit = (byte_n == 2'd2) && (pos == 4'd8);
    assign dly_end  = (dcnt == DW'(DELAY_CYC - 1));
    assign bus      = (state == START) || (state == BITS) ||
                      (state == STOP)  || (state == GAP);
    assign cam_enable = done && !ack_err;

`ifdef SCCB_ACK_CHECK_EN
    assign ack_hit = (state == BITS) && tick && (q == 2'd2) &&
                     (pos == 4'd8) && siod_in;
`else
    assign ack_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (start) next_state = LOAD;
            LOAD: begin
                if (lwait) begin
                    if (rom_entry == 16'hFFFF)      next_state = DONE;
                    else if (rom_entry == 16'hFFF0) next_state = DELAY;
                    else                            next_state = START;
                end
            end
            START: if (q_end) next_state = BITS;
            BITS:  if (q_end && last_bit) next_state = STOP;
            STOP:  if (q_end) next_state = GAP;
            GAP: begin
                if (q_end)
                    next_state = (ack_err || rom_index == 8'hFF) ? DONE : LOAD;
            end
            DELAY: begin
                if (dly_end)
                    next_state = (rom_index == 8'hFF) ? DONE : LOAD;
            end
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Idle/released bus is the default; ACK slots are always released.
    always_comb begin
        sioc     = 1'b1;
        siod_out = 1'b1;
        siod_oe  = 1'b0;
        unique case (state)
            START: begin
                siod_oe  = 1'b1;
                siod_out = (q == 2'd0);
                sioc     = !q[1];
            end
            BITS: begin
                sioc     = q[1];
                siod_oe  = (pos != 4'd8);
                siod_out = (pos == 4'd8) ? 1'b1 : shreg[26];
            end
            STOP: begin
                siod_oe  = 1'b1;
                sioc     = (q != 2'd0);
                siod_out = q[1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qcnt      <= '0;
            q         <= '0;
            pos       <= '0;
            byte_n    <= '0;
            shreg     <= '1;
            dcnt      <= '0;
            lwait     <= 1'b0;
            rom_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_err   <= 1'b0;
        end else begin
            qcnt  <= (bus && !tick) ? qcnt + QW'(1) : '0;
            lwait <= (state == LOAD) && !lwait;
            dcnt  <= (state == DELAY) ? dcnt + DW'(1) : '0;
            if (!bus)      q <= '0;
            else if (tick) q <= q + 2'd1;
            if (state != BITS) begin
                pos    <= '0;
                byte_n <= '0;
            end else if (q_end) begin
                shreg <= {shreg[25:0], 1'b1};
                if (pos == 4'd8) begin
                    pos    <= '0;
                    byte_n <= byte_n + 2'd1;
                end else begin
                    pos <= pos + 4'd1;
                end
            end
            if (state == LOAD && lwait)
                shreg <= {DEV_ID, 1'b1, rom_entry[15:8], 1'b1,
                          rom_entry[7:0], 1'b1};
            if (state == IDLE && start) begin
                rom_index <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                ack_err   <= 1'b0;
            end
            if (next_state == LOAD && (state == GAP || state == DELAY))
                rom_index <= rom_index + 8'd1;
            if (ack_hit)
                ack_err <= 1'b1;
            if (state == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Random-table bench: decodes the SCCB pins and compares writes against a
// table-walk model.
module tb_sccb_cfg_sequencer;

    localparam int         DLY = 20;
    localparam logic [7:0] ID  = 8'h42;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_index;
    logic [15:0] rom_entry;
    logic        sioc, siod_out, siod_oe, busy, done, cam_enable, ack_err;
    logic [15:0] rom [256];

    int n_vec = 0;
    int n_err = 0;

    // bus monitor state
    logic        p_scl = 1'b1;
    logic        p_sda = 1'b1;
    logic        sda;
    logic        in_frame = 1'b0;
    int          mon_bits = 0;
    logic [23:0] mon_sh;
    logic [23:0] frames[$];
    int          bad_frames = 0;
    int          ack_drv = 0;

    assign rom_entry = rom[rom_index];

`ifdef SCCB_ACK_CHECK_EN
    logic ack_fault = 1'b0;
    logic siod_in;
    assign siod_in = ack_fault && in_frame && (mon_bits == 18);
`endif

    sccb_cfg_sequencer #(
        .CLK_HZ(400_000), .SCCB_HZ(100_000), .DEV_ID(ID), .DELAY_CYC(DLY)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .rom_index(rom_index), .rom_entry(rom_entry),
`ifdef SCCB_ACK_CHECK_EN
        .siod_in(siod_in),
`endif
        .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe),
        .busy(busy), .done(done), .cam_enable(cam_enable), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        sda = siod_oe ? siod_out : 1'b1;
        if (rst) begin
            in_frame = 1'b0;
            mon_bits = 0;
        end else if (sioc && p_scl && p_sda && !sda) begin
            in_frame = 1'b1;
            mon_bits = 0;
            mon_sh   = '0;
        end else if (sioc && p_scl && !p_sda && sda && in_frame) begin
            in_frame = 1'b0;
            if (mon_bits == 28) frames.push_back(mon_sh);
            else bad_frames++;
        end else if (sioc && !p_scl && in_frame) begin
            if (mon_bits % 9 == 8) begin
                if (siod_oe) ack_drv++;
            end else if (mon_bits < 27) begin
                mon_sh = {mon_sh[22:0], sda};
            end
            mon_bits++;
        end
        p_scl = sioc;
        p_sda = sda;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Walk the table as the camera should see it and compare the decoded bus.
    task automatic run_table(input string tag, input int pulse_at,
                             output int first_low);
        logic [23:0] expq[$];
        int end_idx = 255;
        int nd = 0;
        int budget, bad0, ack0;
        bit fin = 0;
        for (int i = 0; i < 256; i++) begin
            if (rom[i] == 16'hFFFF) begin
                end_idx = i;
                break;
            end
            if (rom[i] == 16'hFFF0) nd++;
            else expq.push_back({ID, rom[i]});
        end
        budget = expq.size() * 140 + nd * (DLY + 4) + 100;
        frames.delete();
        bad0 = bad_frames;
        ack0 = ack_drv;
        pulse_start();
        check({tag, "_busy_up"}, busy, 1);
        check({tag, "_done_drop"}, done, 0);
        first_low = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (first_low < 0 && !sioc) first_low = c;
            if (done) begin
                fin = 1;
                break;
            end
            start = (c == pulse_at);
        end
        start = 1'b0;
        check({tag, "_finished"}, fin, 1);
        check({tag, "_index"}, rom_index, end_idx);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_cam_en"}, cam_enable, 1);
        check({tag, "_ack_err"}, ack_err, 0);
        check({tag, "_nwrites"}, frames.size(), expq.size());
        for (int i = 0; i < expq.size() && i < frames.size(); i++)
            check({tag, "_write"}, frames[i], expq[i]);
        check({tag, "_frame_err"}, bad_frames - bad0, 0);
        check({tag, "_ack_driven"}, ack_drv - ack0, 0);
    endtask

    initial begin
        int fl;
        bit hit;
        logic [15:0] e;
        foreach (rom[i]) rom[i] = 16'hFFFF;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_sioc", sioc, 1);
        check("rst_oe", siod_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_index", rom_index, 0);
        check("rst_cam", cam_enable, 0);

        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        run_table("single", 0, fl);

        // start issued after done replays the table from entry 0
        run_table("restart", 0, fl);

        rom[0] = 16'hFFF0; rom[1] = 16'h1101; rom[2] = 16'hFFFF;
        run_table("delay", 0, fl);
        check("delay_quiet", fl >= DLY, 1);

        rom[0] = 16'h3344; rom[1] = 16'h5566; rom[2] = 16'hFFFF;
        run_table("busy_ign", 40, fl);

        // reset wins over a coincident start
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        check("rst_vs_start", busy, 0);

        rom[0] = 16'h1280; rom[1] = 16'h3456; rom[2] = 16'hFFFF;
        pulse_start();
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (in_frame && mon_bits == 21) begin
                hit = 1;
                break;
            end
        end
        check("midrst_reach", hit, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_sioc", sioc, 1);
        check("midrst_oe", siod_oe, 0);
        check("midrst_busy", busy, 0);
        check("midrst_index", rom_index, 0);
        rst = 1'b0;
        run_table("replay", 0, fl);

        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                e = 16'($urandom);
                if (e == 16'hFFFF || e == 16'hFFF0) e = 16'h1234;
                rom[i] = ($urandom_range(0, 4) == 0) ? 16'hFFF0 : e;
            end
            rom[n] = 16'hFFFF;
            run_table("rand", (r % 2 == 1) ? $urandom_range(10, 200) : 0, fl);
        end

        // no end marker: entry 0xFF is the last one processed
        for (int i = 0; i < 255; i++) rom[i] = 16'hFFF0;
        rom[255] = 16'hABCD;
        run_table("no_wrap", 0, fl);

`ifdef SCCB_ACK_CHECK_EN
        rom[0] = 16'h1280; rom[1] = 16'h3456; rom[2] = 16'hFFFF;
        frames.delete();
        ack_fault = 1'b1;
        pulse_start();
        hit = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (done) begin
                hit = 1;
                break;
            end
        end
        ack_fault = 1'b0;
        check("ack_finished", hit, 1);
        check("ack_err_set", ack_err, 1);
        check("ack_cam_off", cam_enable, 0);
        check("ack_nwrites", frames.size(), 1);
        check("ack_index", rom_index, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
